// File: rtl/ram_arb_if.sv
// Request/grant bundle for the fetch (IF) and load/store (DM) ports, plus the RAM port.
// The arbiter takes the slave side; requesters and the RAM model take the master side.
interface ram_arb_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_q,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_cen, mem_wen, mem_a, mem_d
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_q,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_cen, mem_wen, mem_a, mem_d
  );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Single-port RAM arbiter: round-robin between fetch and load/store ports with
// combinational grant, one-cycle read latency, and a one-cycle LOAD state for image reload.
module ram_arb_ctrl #(
  parameter int DW            = 16,
  parameter int AW            = 9,
  parameter bit LOAD_ON_RESET = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load_req,
  output logic       o_busy,
  ram_arb_if.slave   io_bus,
  output logic [2:0] o_mem_ema,
  output logic [1:0] o_mem_emaw,
  output logic       o_mem_emas,
  output logic       o_mem_ret1n
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_dm;
  logic          w_if_gnt;
  logic          w_dm_gnt;
  logic          w_dm_rd;
  logic          w_cen;
  logic          w_wen;
  logic          w_busy;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d;

  logic          r_if_rvalid_p1;
  logic          r_dm_rvalid_p1;
  logic [DW-1:0] r_if_rdata_p1;
  logic [DW-1:0] r_dm_rdata_p1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= LOAD_ON_RESET ? ST_LOAD : ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset forces every output to its idle value, so the reset path relies on the defaults.
  always_comb begin
    w_state_nxt = r_state;
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_cen       = 1'b0;
    w_wen       = 1'b0;
    w_a         = '0;
    w_d         = '0;
    w_busy      = 1'b1;
    if (i_rst_n) begin
      case (r_state)
        ST_LOAD: begin
          w_cen       = 1'b1;
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          w_busy = 1'b0;
          if (io_bus.if_req && (!io_bus.dm_req || r_last_dm)) begin
            w_if_gnt = 1'b1;
          end else if (io_bus.dm_req) begin
            w_dm_gnt = 1'b1;
          end
          if (w_if_gnt) begin
            w_a = io_bus.if_addr;
          end else if (w_dm_gnt) begin
            w_a   = io_bus.dm_addr;
            w_wen = io_bus.dm_we;
            if (io_bus.dm_we) begin
              w_d = io_bus.dm_wdata;
            end
          end
          if (i_load_req) begin
            w_state_nxt = ST_LOAD;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign w_dm_rd = w_dm_gnt & ~io_bus.dm_we;

  // Stage p0 -> p1: capture RAM read data one cycle after the grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_dm      <= 1'b1;
      r_if_rvalid_p1 <= 1'b0;
      r_dm_rvalid_p1 <= 1'b0;
      r_if_rdata_p1  <= '0;
      r_dm_rdata_p1  <= '0;
    end else begin
      r_if_rvalid_p1 <= w_if_gnt;
      r_dm_rvalid_p1 <= w_dm_rd;
      if (w_if_gnt) begin
        r_if_rdata_p1 <= io_bus.mem_q;
      end
      if (w_dm_rd) begin
        r_dm_rdata_p1 <= io_bus.mem_q;
      end
      if (w_if_gnt || w_dm_gnt) begin
        r_last_dm <= w_dm_gnt;
      end
    end
  end

  assign io_bus.if_gnt    = w_if_gnt;
  assign io_bus.dm_gnt    = w_dm_gnt;
  assign io_bus.mem_cen   = w_cen;
  assign io_bus.mem_wen   = w_wen;
  assign io_bus.mem_a     = w_a;
  assign io_bus.mem_d     = w_d;
  // Read responses vanish as soon as reset is asserted, not one edge later.
  assign io_bus.if_rvalid = r_if_rvalid_p1 & i_rst_n;
  assign io_bus.dm_rvalid = r_dm_rvalid_p1 & i_rst_n;
  assign io_bus.if_rdata  = i_rst_n ? r_if_rdata_p1 : '0;
  assign io_bus.dm_rdata  = i_rst_n ? r_dm_rdata_p1 : '0;
  assign o_busy           = w_busy;

  assign o_mem_ema   = 3'd0;
  assign o_mem_emaw  = 2'd0;
  assign o_mem_emas  = 1'b0;
  assign o_mem_ret1n = 1'b1;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Directed bench for ram_arb_ctrl: a RAM model, a read-response scoreboard and
// cycle-by-cycle grant/RAM-port checks.
module tb_ram_arb_ctrl;
  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk;
  logic          rst_n;
  logic          load_req;
  logic          busy;
  logic [2:0]    ema;
  logic [1:0]    emaw;
  logic          emas;
  logic          ret1n;

  logic          ld_en;
  logic [AW-1:0] ld_a;
  logic [DW-1:0] ld_d;
  logic [DW-1:0] mem [512];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            dm;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q [$];

  ram_arb_if #(.DW(DW), .AW(AW)) bus ();

  ram_arb_ctrl #(.DW(DW), .AW(AW), .LOAD_ON_RESET(1'b1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_load_req  (load_req),
    .o_busy      (busy),
    .io_bus      (bus),
    .o_mem_ema   (ema),
    .o_mem_emaw  (emaw),
    .o_mem_emas  (emas),
    .o_mem_ret1n (ret1n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_q = mem[bus.mem_a];

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (!bus.mem_cen && bus.mem_wen) mem[bus.mem_a] <= bus.mem_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every read response is matched against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_rvalid || bus.dm_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got if=%b dm=%b expected none at %0t",
                 bus.if_rvalid, bus.dm_rvalid, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_port", 32'({bus.if_rvalid, bus.dm_rvalid}), e.dm ? 32'd1 : 32'd2);
        chk("rd_data", 32'(e.dm ? bus.dm_rdata : bus.if_rdata), 32'(e.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit dm, input logic [DW-1:0] data);
    exp_t e;
    e.dm   = dm;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit ir, input logic [AW-1:0] ia,
                       input bit dr, input bit we, input logic [AW-1:0] da,
                       input logic [DW-1:0] wd);
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = we;
    bus.dm_addr  = da;
    bus.dm_wdata = wd;
  endtask

  task automatic chk_gnt(input string nm, input logic [1:0] exp);
    chk(nm, 32'({bus.if_gnt, bus.dm_gnt}), 32'(exp));
  endtask

  initial begin
    logic [AW-1:0] pa [4];
    logic [DW-1:0] pd [4];
    pa = '{9'h005, 9'h010, 9'h020, 9'h030};
    pd = '{16'h1234, 16'hA5A5, 16'h0F0F, 16'h3333};
    rst_n    = 1'b0;
    load_req = 1'b0;
    ld_en    = 1'b0;
    ld_a     = '0;
    ld_d     = '0;
    drive(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      cyc();
      ld_en = 1'b1;
      ld_a  = pa[i];
      ld_d  = pd[i];
    end
    cyc();
    ld_en = 1'b0;
    @(negedge clk);
    chk_gnt("reset_gnt", 2'b00);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_cen_wen", 32'({bus.mem_cen, bus.mem_wen}), 32'd0);
    chk("reset_a_d", 32'({bus.mem_a, bus.mem_d}), 32'd0);
    chk("reset_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'd0);
    chk("reset_rdata", 32'({bus.if_rdata, bus.dm_rdata}), 32'd0);
    chk("tie_offs", 32'({ema, emaw, emas, ret1n}), 32'd1);

    // Release with both requesters active: LOAD cycle grants nothing.
    cyc();
    rst_n = 1'b1;
    drive(1, 9'h010, 1, 0, 9'h020, 0);
    @(negedge clk);
    chk("load_cen", 32'(bus.mem_cen), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    chk_gnt("load_gnt", 2'b00);

    // Continuous conflict: IF, DM, IF, DM.
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk_gnt("rr_conflict", (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("run_cen_busy", 32'({bus.mem_cen, busy}), 32'd0);
      chk("rr_addr", 32'(bus.mem_a), (i % 2 == 0) ? 32'h010 : 32'h020);
      push(i % 2 == 1, (i % 2 == 0) ? 16'hA5A5 : 16'h0F0F);
    end

    cyc();
    drive(1, 9'h005, 0, 0, 0, 0);
    @(negedge clk);
    chk_gnt("if_solo_gnt", 2'b10);
    chk("if_solo_a", 32'(bus.mem_a), 32'h005);
    chk("if_solo_wen", 32'(bus.mem_wen), 32'd0);
    push(0, 16'h1234);

    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_gnt("idle_gnt", 2'b00);
    chk("idle_wen_a_d", 32'({bus.mem_wen, bus.mem_a, bus.mem_d}), 32'd0);

    cyc();
    @(negedge clk);
    chk("rdata_hold_valid", 32'(bus.if_rvalid), 32'd0);
    chk("rdata_hold", 32'(bus.if_rdata), 32'h1234);

    // Last grant was IF; idle cycles must not move the pointer, so DM wins.
    cyc();
    drive(1, 9'h010, 1, 0, 9'h020, 0);
    @(negedge clk);
    chk_gnt("rr_after_idle", 2'b01);
    push(1, 16'h0F0F);

    cyc();
    drive(1, 9'h010, 0, 0, 0, 0);
    @(negedge clk);
    chk_gnt("if_held", 2'b10);
    push(0, 16'hA5A5);

    cyc();
    drive(0, 0, 1, 1, 9'h1FF, 16'hBEEF);
    @(negedge clk);
    chk_gnt("dm_wr_gnt", 2'b01);
    chk("dm_wr_wen", 32'(bus.mem_wen), 32'd1);
    chk("dm_wr_a", 32'(bus.mem_a), 32'h1FF);
    chk("dm_wr_d", 32'(bus.mem_d), 32'hBEEF);

    cyc();
    drive(0, 0, 1, 0, 9'h1FF, 0);
    @(negedge clk);
    chk("dm_wr_no_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk_gnt("dm_rd_gnt", 2'b01);
    chk("dm_rd_d_zero", 32'({bus.mem_wen, bus.mem_d}), 32'd0);
    push(1, 16'hBEEF);

    cyc();
    drive(0, 0, 1, 0, 9'h020, 0);
    @(negedge clk);
    chk_gnt("dm_b2b_gnt", 2'b01);
    push(1, 16'h0F0F);

    // Reload request alongside an IF access.
    cyc();
    drive(1, 9'h005, 0, 0, 0, 0);
    load_req = 1'b1;
    @(negedge clk);
    chk_gnt("ldreq_if_gnt", 2'b10);
    push(0, 16'h1234);

    cyc();
    drive(1, 9'h010, 1, 0, 9'h020, 0);
    @(negedge clk);
    chk("reload_cen", 32'(bus.mem_cen), 32'd1);
    chk("reload_busy", 32'(busy), 32'd1);
    chk_gnt("reload_gnt", 2'b00);

    cyc();
    load_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("after_load_cen_busy", 32'({bus.mem_cen, busy}), 32'd0);

    // Reset right after a DM read grant, with a write pending during reset.
    cyc();
    drive(0, 0, 1, 0, 9'h020, 0);
    @(negedge clk);
    chk_gnt("pre_rst_gnt", 2'b01);

    cyc();
    rst_n    = 1'b0;
    load_req = 1'b1;
    drive(1, 9'h005, 1, 1, 9'h030, 16'hDEAD);
    @(negedge clk);
    chk("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk("rst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
    chk_gnt("rst_gnt", 2'b00);
    chk("rst_cen_wen", 32'({bus.mem_cen, bus.mem_wen}), 32'd0);

    cyc();
    rst_n    = 1'b1;
    load_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rel_load_cen_busy", 32'({bus.mem_cen, busy}), 32'd3);

    cyc();
    @(negedge clk);
    chk("rel_run_busy", 32'(busy), 32'd0);

    cyc();
    drive(0, 0, 1, 0, 9'h030, 0);
    @(negedge clk);
    chk_gnt("no_write_in_rst_gnt", 2'b01);
    push(1, 16'h3333);

    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arb_ctrl.md
RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, RAM data width.
REQ-002 SHALL have parameter AW, default 9, RAM address width (512 words).
REQ-003 SHALL have parameter LOAD_ON_RESET, default 1, 1 = run one image-load cycle after reset release.
REQ-004 SHALL use one clock; reset is synchronous and active-low: CLK  in  1  rising-edge clock; RST_N  in  1  synchronous active-low reset.
REQ-005 SHALL have LOAD_REQ  in  1  pulse requesting a RAM image reload.
REQ-006 SHALL have BUSY  out  1  high while not in RUN.
REQ-007 SHALL have IF_REQ  in  1 / IF_ADDR  in  AW / IF_GNT  out  1 / IF_RVALID  out  1 / IF_RDATA  out  DW: read-only fetch port.
REQ-008 SHALL have DM_REQ  in  1 / DM_WE  in  1 / DM_ADDR  in  AW / DM_WDATA  in  DW / DM_GNT  out  1 / DM_RVALID  out  1 / DM_RDATA  out  DW: load/store port.
REQ-009 SHALL have MEM_CEN  out  1 / MEM_WEN  out  1 / MEM_A  out  AW / MEM_D  out  DW / MEM_Q  in  DW: RAM port; MEM_Q is combinational read of MEM_A.
REQ-010 SHALL drive constants MEM_EMA  out  3 = 0, MEM_EMAW  out  2 = 0, MEM_EMAS  out  1 = 0, MEM_RET1N  out  1 = 1.

Function
REQ-011 SHALL use FSM states LOAD and RUN only.
REQ-012 LOAD SHALL last exactly one cycle: MEM_CEN=1, MEM_WEN=0, no grants, BUSY=1; next state RUN.
REQ-013 RUN SHALL keep MEM_CEN=0; idle cycle (no grant) drives MEM_WEN=0, MEM_A=0, MEM_D=0.
REQ-014 RUN: grant is combinational, same cycle as REQ; exactly one of IF_GNT/DM_GNT or none per cycle.
REQ-015 Only one requester high: that requester is granted.
REQ-016 Both high: grant goes to port opposite the last granted port; rr pointer resets to "last = DM" (IF wins first conflict).
REQ-017 rr pointer SHALL update only on a cycle with a grant.
REQ-018 Granted IF: MEM_A=IF_ADDR, MEM_WEN=0; MEM_Q registered into IF_RDATA, IF_RVALID=1 next cycle for exactly one cycle.
REQ-019 Granted DM read (DM_WE=0): MEM_A=DM_ADDR, MEM_WEN=0; DM_RDATA/DM_RVALID as REQ-018, latency 1.
REQ-020 Granted DM write (DM_WE=1): MEM_A=DM_ADDR, MEM_D=DM_WDATA, MEM_WEN=1; DM_RVALID stays 0.
REQ-021 Requester SHALL hold REQ/ADDR/WDATA until GNT; ungranted request is not queued internally.
REQ-022 RDATA SHALL hold last captured value when RVALID=0.
REQ-023 LOAD_REQ=1 in RUN: current-cycle grant proceeds normally; next cycle is LOAD.
REQ-024 LOAD_REQ during LOAD ignored; LOAD_REQ simultaneous with reset ignored.
REQ-025 Back-to-back grants to same port allowed every cycle when other port idle (full throughput, 1 access/cycle).
REQ-026 Address SHALL pass unmodified; no wrap or range checking (AW bits fill 512 words).

Reset
REQ-027 While RST_N=0: GNTs=0, RVALIDs=0, RDATAs=0, MEM_CEN=0, MEM_WEN=0, MEM_A=0, MEM_D=0, BUSY=1.
REQ-028 First cycle after RST_N rises: state LOAD if LOAD_ON_RESET=1, else RUN with BUSY=0.
REQ-029 Reset asserted mid-access SHALL cancel pending RVALID next edge; no write issued in a reset cycle.

Verification
REQ-030 Reset release, LOAD_ON_RESET=1 -> cycle 1 MEM_CEN=1 BUSY=1, cycle 2 MEM_CEN=0 BUSY=0.
REQ-031 IF_REQ, IF_ADDR=0x005, MEM_Q=0x1234 -> IF_GNT same cycle, IF_RVALID=1 and IF_RDATA=0x1234 next cycle.
REQ-032 IF_REQ and DM_REQ held high 4 cycles from reset -> grants IF,DM,IF,DM.
REQ-033 DM write ADDR=0x1FF WDATA=0xBEEF -> MEM_WEN=1, MEM_A=0x1FF, MEM_D=0xBEEF, DM_RVALID=0 next cycle.
REQ-034 LOAD_REQ pulse during IF access -> that IF access completes with IF_RVALID, next cycle MEM_CEN=1 and no grants despite pending requests.
REQ-035 RST_N low in cycle after a DM read grant -> DM_RVALID=0, DM_RDATA=0.
